// File: rtl/word_packer.sv
// word_packer: packs RATIO input words into one wide output word.
// A word carrying i_in_last closes the output word early and zero-fills the unused lanes.
module word_packer #(
  parameter int WIDTH_IN  = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_arst_n,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [WIDTH_IN-1:0]           i_in_data,
  input  logic                          i_in_last,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [WIDTH_IN*RATIO-1:0]     o_out_data,
  output logic [$clog2(RATIO+1)-1:0]    o_out_count,
  output logic                          o_out_last
);
  localparam int OW = WIDTH_IN * RATIO;
  localparam int KW = $clog2(RATIO);
  localparam int CW = $clog2(RATIO + 1);
  generate
    if (WIDTH_IN < 1 || RATIO < 2) begin : g_bad_params
      $error("word_packer: WIDTH_IN must be >= 1 and RATIO >= 2");
    end
  endgenerate
  logic [OW-1:0] acc_data;
  logic [KW-1:0] acc_cnt;
  logic [KW-1:0] lane;
  logic [OW-1:0] merged;
  logic          fire;
  logic          done;
  assign o_in_ready = !o_out_valid || i_out_ready;
  assign fire       = i_in_valid && o_in_ready;
  assign done       = fire && (acc_cnt == KW'(RATIO - 1) || i_in_last);
  assign lane       = MSB_FIRST ? KW'(RATIO - 1) - acc_cnt : acc_cnt;
  assign merged     = acc_data | (OW'(i_in_data) << (int'(lane) * WIDTH_IN));
  // A completing word bypasses the accumulator straight into the output register.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      acc_data    <= '0;
      acc_cnt     <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_count <= '0;
      o_out_last  <= 1'b0;
    end else begin
      if (fire) begin
        acc_data <= done ? '0 : merged;
        acc_cnt  <= done ? '0 : acc_cnt + KW'(1);
      end
      if (done) begin
        o_out_valid <= 1'b1;
        o_out_data  <= merged;
        o_out_count <= CW'(acc_cnt) + CW'(1);
        o_out_last  <= i_in_last;
      end else if (i_out_ready) begin
        o_out_valid <= 1'b0;
      end
    end
  end
endmodule
